// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU constants for the memory stage: data and register-index widths,
// byte-lane encoding and the load-data extraction helper.
package mem_wb_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Byte lanes within a little-endian 32-bit word, selected by address bits [1:0].
    localparam logic [1:0] BYTE_LANE0 = 2'd0;  // bits [7:0]
    localparam logic [1:0] BYTE_LANE1 = 2'd1;  // bits [15:8]
    localparam logic [1:0] BYTE_LANE2 = 2'd2;  // bits [23:16]
    localparam logic [1:0] BYTE_LANE3 = 2'd3;  // bits [31:24]

    // Full word for lw, sign-extended selected byte for lb.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0]        lane,
                                                       input logic              lb);
        logic [7:0] byte_val;
        byte_val = word[7:0];
        case (lane)
            BYTE_LANE0: byte_val = word[7:0];
            BYTE_LANE1: byte_val = word[15:8];
            BYTE_LANE2: byte_val = word[23:16];
            BYTE_LANE3: byte_val = word[31:24];
            default:    byte_val = word[7:0];
        endcase
        return lb ? {{(DATA_W-8){byte_val[7]}}, byte_val} : word;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB bundle of the memory stage.
//   master : drives the EX/MEM control/data bits and the debug address,
//            observes forwarding, writeback, halt, counters and debug data.
//   slave  : the memory stage itself.
interface mem_wb_stage_if #(parameter int ADDR_W = 10);
    import mem_wb_stage_pkg::*;

    logic              halt_i;
    logic              Regwrite_i;
    logic              Memwrite_i;
    logic              MemToReg_i;
    logic              lb_i;
    logic [REG_W-1:0]  desreg_i;
    logic [DATA_W-1:0] ALU_i;
    logic [DATA_W-1:0] mem_din_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [ADDR_W-1:0] dbg_addr_i;

    logic [DATA_W-1:0] fwd_data_o;
    logic              fwd_we_o;
    logic [REG_W-1:0]  fwd_reg_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              wb_we_o;
    logic [REG_W-1:0]  wb_reg_o;
    logic              halt_o;
    logic [DATA_W-1:0] cycles_o;
    logic [DATA_W-1:0] memops_o;
    logic [DATA_W-1:0] dbg_data_o;

    modport master (
        output halt_i, Regwrite_i, Memwrite_i, MemToReg_i, lb_i, desreg_i,
               ALU_i, mem_din_i, wb_data_i, dbg_addr_i,
        input  fwd_data_o, fwd_we_o, fwd_reg_o, wb_data_o, wb_we_o, wb_reg_o,
               halt_o, cycles_o, memops_o, dbg_data_o
    );

    modport slave (
        input  halt_i, Regwrite_i, Memwrite_i, MemToReg_i, lb_i, desreg_i,
               ALU_i, mem_din_i, wb_data_i, dbg_addr_i,
        output fwd_data_o, fwd_we_o, fwd_reg_o, wb_data_o, wb_we_o, wb_reg_o,
               halt_o, cycles_o, memops_o, dbg_data_o
    );

endinterface

// File: rtl/mem_wb_stage_dmem.sv
// Data RAM: 2^ADDR_W words of 32 bits.
//   clk        : write clock
//   we_i       : synchronous word write enable
//   addr_i     : word address shared by write and access read
//   wdata_i    : write data
//   rdata_o    : asynchronous read of addr_i (old word during a write)
//   dbg_addr_i : debug word address
//   dbg_data_o : asynchronous debug read
// No reset: contents survive a CPU reset.
module dmem
    import mem_wb_stage_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : EX/MEM inputs, same-cycle forwarding outputs, registered writeback,
//         sticky halt, cycle/memop counters and RAM debug read port
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    logic [ADDR_W-1:0] word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] fwd_data;
    logic              fwd_we;
    logic              mem_we;

    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_we_q,   wb_we_d;
    logic [REG_W-1:0]  wb_reg_q,  wb_reg_d;
    logic              halt_q,    halt_d;
    logic [DATA_W-1:0] cycles_q,  cycles_d;
    logic [DATA_W-1:0] memops_q,  memops_d;

    // Address bits above the RAM are ignored so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ALU_i[DATA_W-1:ADDR_W+2];

    assign word_idx = bus.ALU_i[ADDR_W+1:2];

    // Store is blocked once halted, and in the reset cycle itself.
    assign mem_we = bus.Memwrite_i & ~halt_q & rst;

    dmem #(.ADDR_W(ADDR_W)) u_dmem (
        .clk        (clk),
        .we_i       (mem_we),
        .addr_i     (word_idx),
        .wdata_i    (bus.mem_din_i),
        .rdata_o    (rd_word),
        .dbg_addr_i (bus.dbg_addr_i),
        .dbg_data_o (bus.dbg_data_o)
    );

    assign fwd_data = bus.MemToReg_i ? load_extract(rd_word, bus.ALU_i[1:0], bus.lb_i)
                                     : bus.wb_data_i;
    assign fwd_we   = bus.Regwrite_i & ~halt_q;

    always_comb begin
        wb_data_d = fwd_data;
        wb_we_d   = fwd_we;
        wb_reg_d  = bus.desreg_i;
        halt_d    = halt_q | bus.halt_i;
        cycles_d  = cycles_q;
        memops_d  = memops_q;
        // The cycle carrying halt_i is still counted: halt_q is not yet set.
        if (!halt_q) begin
            cycles_d = cycles_q + 32'd1;
            if (bus.Memwrite_i | bus.MemToReg_i) begin
                memops_d = memops_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_reg_q  <= '0;
            halt_q    <= 1'b0;
            cycles_q  <= '0;
            memops_q  <= '0;
        end else begin
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            wb_reg_q  <= wb_reg_d;
            halt_q    <= halt_d;
            cycles_q  <= cycles_d;
            memops_q  <= memops_d;
        end
    end

    assign bus.fwd_data_o = fwd_data;
    assign bus.fwd_we_o   = fwd_we;
    assign bus.fwd_reg_o  = bus.desreg_i;
    assign bus.wb_data_o  = wb_data_q;
    assign bus.wb_we_o    = wb_we_q;
    assign bus.wb_reg_o   = wb_reg_q;
    assign bus.halt_o     = halt_q;
    assign bus.cycles_o   = cycles_q;
    assign bus.memops_o   = memops_q;

endmodule
